// File: rtl/charge_station.sv
// charge_station
//
// Multi-port charging-station controller. Every port runs its own
// IDLE -> ENTRY -> CHARGE state machine. The shared keypad and display
// are routed to one port at a time by chan_sel.
//
// Optional feature macro: CHARGE_ABORT_EN
//   defined   : a clear key on a charging port aborts the charge at once
//   undefined : clear is ignored while a port is charging
//
// Parameters
//   CHANNELS     number of independent ports (1..8)
//   MAX_MONEY    upper clamp for the entered amount
//   RATE         minutes of charge per money unit (MAX_MONEY*RATE <= 254)
//   TICK_DIV     CLK cycles per minute tick
//   IDLE_TIMEOUT CLK cycles of keypad inactivity before an entry is dropped
//
// Ports
//   CLK       in   clock, rising edge
//   RST       in   asynchronous active-high reset
//   startSet  in   key strobe; its rising edge is the set event
//   chan_sel  in   port addressed by keypad and display
//   num       in   digit key, values of 10 or more mean "no digit"
//   start     in   start key
//   clear     in   clear key
//   enter     in   enter key
//   money     out  money of the selected port (8'hFF when idle/invalid)
//   restime   out  remaining minutes of the selected port (8'hFF when idle/invalid)
//   busy      out  bit i high while port i is charging

module charge_station #(
  parameter int CHANNELS     = 2,
  parameter int MAX_MONEY    = 20,
  parameter int RATE         = 2,
  parameter int TICK_DIV     = 25000,
  parameter int IDLE_TIMEOUT = 250000,
  localparam int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                startSet,
  input  logic [SEL_W-1:0]    chan_sel,
  input  logic [4:0]          num,
  input  logic                start,
  input  logic                clear,
  input  logic                enter,
  output logic [7:0]          money,
  output logic [7:0]          restime,
  output logic [CHANNELS-1:0] busy
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [7:0]        MAX_M     = 8'(MAX_MONEY);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHARGE
  } state_t;

  typedef enum logic [2:0] {
    KEY_NONE,
    KEY_DIGIT,
    KEY_START,
    KEY_CLEAR,
    KEY_ENTER
  } key_t;

  // Per-port registers
  state_t            state_q   [CHANNELS];
  state_t            state_d   [CHANNELS];
  logic [7:0]        money_q   [CHANNELS];
  logic [7:0]        money_d   [CHANNELS];
  logic [7:0]        restime_q [CHANNELS];
  logic [7:0]        restime_d [CHANNELS];
  logic [TICK_W-1:0] tick_q    [CHANNELS];
  logic [TICK_W-1:0] tick_d    [CHANNELS];
  logic [IDLE_W-1:0] idle_q    [CHANNELS];
  logic [IDLE_W-1:0] idle_d    [CHANNELS];
  logic              armed_q   [CHANNELS];
  logic              armed_d   [CHANNELS];

  // Shared keypad registers
  logic start_set_q;
  logic start_set_d;
  logic set_en_q;
  logic set_en_d;

  logic sel_valid;
  logic set_evt;
  key_t key;

  // The set event needs the previous startSet sample, and is also held off
  // until one full clock has passed since reset release so that a strobe
  // already high when reset drops cannot fire on the very first edge.
  always_comb begin
    sel_valid   = (int'(32'(chan_sel)) < CHANNELS);
    start_set_d = startSet;
    set_en_d    = 1'b1;
    set_evt     = startSet && !start_set_q && set_en_q && sel_valid;
  end

  // Key decode with fixed priority enter > clear > start > digit, so that
  // several keys held together always resolve to exactly one action.
  always_comb begin
    key = KEY_NONE;
    if (enter) begin
      key = KEY_ENTER;
    end else if (clear) begin
      key = KEY_CLEAR;
    end else if (start) begin
      key = KEY_START;
    end else if (num < 5'd10) begin
      key = KEY_DIGIT;
    end
  end

  logic hit;
  int   digit_val;
  int   digit_clamped;

  // Next-state logic for every port. Defaults hold the registers; each state
  // then applies its own timer behaviour first and lets an addressed key
  // action override it, so a key press coinciding with an idle timeout wins.
  always_comb begin
    hit           = 1'b0;
    digit_val     = 0;
    digit_clamped = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i]   = state_q[i];
      money_d[i]   = money_q[i];
      restime_d[i] = restime_q[i];
      tick_d[i]    = tick_q[i];
      idle_d[i]    = idle_q[i];
      armed_d[i]   = armed_q[i];

      hit = set_evt && (int'(32'(chan_sel)) == i);

      case (state_q[i])
        ST_IDLE: begin
          if (hit && key == KEY_START) begin
            state_d[i]   = ST_ENTRY;
            money_d[i]   = 8'd0;
            restime_d[i] = 8'd0;
            armed_d[i]   = 1'b1;
            idle_d[i]    = '0;
          end
        end

        ST_ENTRY: begin
          if (armed_q[i]) begin
            if (idle_q[i] == IDLE_LAST) begin
              state_d[i] = ST_IDLE;
              armed_d[i] = 1'b0;
              idle_d[i]  = '0;
            end else begin
              idle_d[i] = idle_q[i] + IDLE_W'(1);
            end
          end

          if (hit) begin
            case (key)
              KEY_ENTER: begin
                // An empty amount cannot start a charge.
                if (money_q[i] != 8'd0) begin
                  state_d[i] = ST_CHARGE;
                  tick_d[i]  = '0;
                  armed_d[i] = 1'b0;
                  idle_d[i]  = '0;
                end
              end
              KEY_CLEAR, KEY_START: begin
                state_d[i]   = ST_ENTRY;
                money_d[i]   = 8'd0;
                restime_d[i] = 8'd0;
                armed_d[i]   = 1'b1;
                idle_d[i]    = '0;
              end
              KEY_DIGIT: begin
                // Shift in the digit keeping two decimal places, then clamp.
                digit_val     = (int'(money_q[i]) * 10 + int'(num)) % 100;
                digit_clamped = (digit_val > MAX_MONEY) ? MAX_MONEY : digit_val;
                state_d[i]    = ST_ENTRY;
                money_d[i]    = 8'(digit_clamped);
                restime_d[i]  = 8'(digit_clamped * RATE);
                armed_d[i]    = 1'b0;
              end
              default: begin
              end
            endcase
          end
        end

        ST_CHARGE: begin
          if (tick_q[i] == TICK_LAST) begin
            tick_d[i] = '0;
            if (restime_q[i] <= 8'd1) begin
              // Final minute: hand the port back to entry with a fresh timer.
              state_d[i]   = ST_ENTRY;
              money_d[i]   = 8'd0;
              restime_d[i] = 8'd0;
              armed_d[i]   = 1'b1;
              idle_d[i]    = '0;
            end else begin
              restime_d[i] = restime_q[i] - 8'd1;
            end
          end else begin
            tick_d[i] = tick_q[i] + TICK_W'(1);
          end
`ifdef CHARGE_ABORT_EN
          // Abort is refused on the final tick, which already ends the charge.
          if (hit && key == KEY_CLEAR &&
              !(tick_q[i] == TICK_LAST && restime_q[i] <= 8'd1)) begin
            state_d[i]   = ST_ENTRY;
            money_d[i]   = 8'd0;
            restime_d[i] = 8'd0;
            tick_d[i]    = '0;
            armed_d[i]   = 1'b1;
            idle_d[i]    = '0;
          end
`endif
        end

        default: begin
          state_d[i] = ST_IDLE;
        end
      endcase
    end
  end

  // State register for all ports plus the keypad strobe history.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      start_set_q <= 1'b0;
      set_en_q    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]   <= ST_IDLE;
        money_q[i]   <= 8'd0;
        restime_q[i] <= 8'd0;
        tick_q[i]    <= '0;
        idle_q[i]    <= '0;
        armed_q[i]   <= 1'b0;
      end
    end else begin
      start_set_q <= start_set_d;
      set_en_q    <= set_en_d;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]   <= state_d[i];
        money_q[i]   <= money_d[i];
        restime_q[i] <= restime_d[i];
        tick_q[i]    <= tick_d[i];
        idle_q[i]    <= idle_d[i];
        armed_q[i]   <= armed_d[i];
      end
    end
  end

  // Display mux. Looping over ports avoids indexing past the array when
  // chan_sel addresses a port that does not exist.
  always_comb begin
    money   = 8'hFF;
    restime = 8'hFF;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel_valid && int'(32'(chan_sel)) == i && state_q[i] != ST_IDLE) begin
        money   = money_q[i];
        restime = restime_q[i];
      end
    end
  end

  // busy decodes the state register directly.
  always_comb begin
    busy = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      busy[i] = (state_q[i] == ST_CHARGE);
    end
  end

endmodule

// File: tb/tb_charge_station.sv
// tb_charge_station
//
// Directed bench for charge_station with TICK_DIV=4, IDLE_TIMEOUT=20,
// CHANNELS=2. Stimulus pushes expected display/busy values into a queue;
// a separate monitor pops and compares them against the DUT outputs.
// Honours CHARGE_ABORT_EN the same way the design does.

module tb_charge_station;

  localparam int K_START = 0;
  localparam int K_CLEAR = 1;
  localparam int K_ENTER = 2;
  localparam int K_DIGIT = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       startSet = 1'b0;
  logic [0:0] chan_sel = 1'b0;
  logic [4:0] num = 5'd31;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic       enter = 1'b0;
  logic [7:0] money;
  logic [7:0] restime;
  logic [1:0] busy;

  charge_station #(
    .CHANNELS    (2),
    .MAX_MONEY   (20),
    .RATE        (2),
    .TICK_DIV    (4),
    .IDLE_TIMEOUT(20)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .startSet(startSet),
    .chan_sel(chan_sel),
    .num     (num),
    .start   (start),
    .clear   (clear),
    .enter   (enter),
    .money   (money),
    .restime (restime),
    .busy    (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [7:0] m;
    logic [7:0] r;
    logic [1:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   push_cnt = 0;
  int   pop_cnt  = 0;
  int   n_cmp    = 0;
  int   n_fail   = 0;

  task automatic compareValue(input string name, input string field,
                              input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s.%s: got %02h, expected %02h", name, field, got, want);
    end
  endtask

  // Monitor: consumes expectations and compares them one unit later so the
  // outputs have settled from whatever the stimulus just did.
  initial begin
    exp_t e;
    forever begin
      wait (pop_cnt != push_cnt);
      #1;
      e = exp_q.pop_front();
      pop_cnt++;
      compareValue(e.name, "money",   money,         e.m);
      compareValue(e.name, "restime", restime,       e.r);
      compareValue(e.name, "busy",    {6'd0, busy},  {6'd0, e.b});
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] m,
                             input logic [7:0] r, input logic [1:0] b);
    exp_t e;
    e.name = name;
    e.m    = m;
    e.r    = r;
    e.b    = b;
    exp_q.push_back(e);
    push_cnt++;
    #2;
  endtask

  // One key press: raise the strobe after an edge, let the next edge act on
  // it, then release. The action edge is the second edge of the call.
  task automatic applyStimulus(input int ch, input int k, input int d);
    @(posedge CLK);
    #2;
    chan_sel = 1'(ch);
    start    = (k == K_START);
    clear    = (k == K_CLEAR);
    enter    = (k == K_ENTER);
    num      = (k == K_DIGIT) ? 5'(d) : 5'd31;
    startSet = 1'b1;
    @(posedge CLK);
    #2;
    startSet = 1'b0;
    start    = 1'b0;
    clear    = 1'b0;
    enter    = 1'b0;
    num      = 5'd31;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  initial begin
    // Reset state while RST is held
    repeat (3) @(posedge CLK);
    #2;
    checkOutput("reset", 8'hFF, 8'hFF, 2'b00);
    RST = 1'b0;

    // Strobe already high on the first edge after reset must be ignored
    chan_sel = 1'b0;
    start    = 1'b1;
    startSet = 1'b1;
    @(posedge CLK);
    #2;
    checkOutput("early_set", 8'hFF, 8'hFF, 2'b00);
    startSet = 1'b0;
    start    = 1'b0;

    // Port 0: start, 1, 5, enter and run the charge to completion
    applyStimulus(0, K_START, 0);
    checkOutput("a_start", 8'd0, 8'd0, 2'b00);
    applyStimulus(0, K_DIGIT, 1);
    checkOutput("a_dig1", 8'd1, 8'd2, 2'b00);
    applyStimulus(0, K_DIGIT, 5);
    checkOutput("a_dig5", 8'd15, 8'd30, 2'b00);
    applyStimulus(0, K_ENTER, 0);
    checkOutput("a_enter", 8'd15, 8'd30, 2'b01);
    waitCycles(3);
    checkOutput("a_tick3", 8'd15, 8'd30, 2'b01);
    waitCycles(1);
    checkOutput("a_tick4", 8'd15, 8'd29, 2'b01);
    waitCycles(115);
    checkOutput("a_last_min", 8'd15, 8'd1, 2'b01);
    waitCycles(1);
    checkOutput("a_done", 8'd0, 8'd0, 2'b00);
    waitCycles(19);
    checkOutput("a_entry_hold", 8'd0, 8'd0, 2'b00);
    waitCycles(1);
    checkOutput("a_timeout", 8'hFF, 8'hFF, 2'b00);

    // Port 1: clamp, then two-digit wrap back down, then clamp again
    applyStimulus(1, K_START, 0);
    applyStimulus(1, K_DIGIT, 9);
    applyStimulus(1, K_DIGIT, 9);
    checkOutput("b_clamp99", 8'd20, 8'd40, 2'b00);
    applyStimulus(1, K_DIGIT, 1);
    checkOutput("b_wrap201", 8'd1, 8'd2, 2'b00);
    applyStimulus(1, K_DIGIT, 2);
    checkOutput("b_dig12", 8'd12, 8'd24, 2'b00);
    applyStimulus(1, K_DIGIT, 3);
    checkOutput("b_wrap123", 8'd20, 8'd40, 2'b00);

    // Port 0 charges while port 1 goes through a full entry
    applyStimulus(0, K_START, 0);
    applyStimulus(0, K_DIGIT, 5);
    applyStimulus(0, K_ENTER, 0);
    checkOutput("c_ch0_enter", 8'd5, 8'd10, 2'b01);
    applyStimulus(1, K_START, 0);
    applyStimulus(1, K_DIGIT, 3);
    applyStimulus(1, K_ENTER, 0);
    checkOutput("c_ch1_enter", 8'd3, 8'd6, 2'b11);
    chan_sel = 1'b0;
    checkOutput("c_ch0_run", 8'd5, 8'd9, 2'b11);
    waitCycles(2);
    checkOutput("c_ch0_dec", 8'd5, 8'd8, 2'b11);

    // Asynchronous reset in the middle of both charges
    #1;
    RST = 1'b1;
    checkOutput("e_async_rst", 8'hFF, 8'hFF, 2'b00);
    waitCycles(1);
    checkOutput("e_rst_hold", 8'hFF, 8'hFF, 2'b00);
    RST = 1'b0;

    // Entry timeout exactly 20 cycles after the set event
    applyStimulus(0, K_START, 0);
    checkOutput("d_start", 8'd0, 8'd0, 2'b00);
    waitCycles(19);
    checkOutput("d_cycle19", 8'd0, 8'd0, 2'b00);
    waitCycles(1);
    checkOutput("d_cycle20", 8'hFF, 8'hFF, 2'b00);

    // A digit disarms the timer
    applyStimulus(0, K_START, 0);
    applyStimulus(0, K_DIGIT, 4);
    checkOutput("d_digit", 8'd4, 8'd8, 2'b00);
    waitCycles(40);
    checkOutput("d_no_timeout", 8'd4, 8'd8, 2'b00);

    // Clear during a charge
    applyStimulus(0, K_ENTER, 0);
    checkOutput("f_enter", 8'd4, 8'd8, 2'b01);
    applyStimulus(0, K_CLEAR, 0);
`ifdef CHARGE_ABORT_EN
    checkOutput("f_clear", 8'd0, 8'd0, 2'b00);
    waitCycles(2);
    checkOutput("f_after", 8'd0, 8'd0, 2'b00);
`else
    checkOutput("f_clear", 8'd4, 8'd8, 2'b01);
    waitCycles(2);
    checkOutput("f_after", 8'd4, 8'd7, 2'b01);
`endif

    // Let the monitor drain, bounded
    for (int i = 0; i < 20 && pop_cnt != push_cnt; i++) begin
      @(posedge CLK);
    end
    if (pop_cnt != push_cnt) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", push_cnt - pop_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
